bike_heading_ctrl: RTL and testbench
====================================

# bike_heading_ctrl

Registered, multi-player steering controller for the lightbike game. It replaces the per-key combinational decoders. It decodes the raw PS/2 byte stream, including the 0xE0 extended prefix and 0xF0 break prefix, against a per-player parametrised keymap. Each player's latest turn request is held in a one-deep pending buffer and committed to a registered heading on each game tick, with optional reversal lockout. It sits between the PS/2 receiver and the bike movement/collision logic.

## Interface
- NUM_PLAYERS, 2, number of bikes (1..4)
- KEYMAP, {9'h175,9'h174,9'h172,9'h16B, 9'h01D,9'h023,9'h01B,9'h01C}, packed 36*NUM_PLAYERS bits.
  - Player p occupies bits [36p+35:36p].
  - Each player slice is four 9-bit {ext, code} entries ordered up, right, down, left, with up in the MSBs.
  - The default gives P0 W/D/S/A and P1 the arrow keys.
- INIT_HEADING, {2'b11, 2'b01}, packed 2*NUM_PLAYERS bits; heading loaded on reset. Default is P0 right, P1 left.
- clock  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high; clears all state on the next clock edge
- ps2_key_pressed  input  1  one-cycle strobe: ps2_key_data is a new byte
- ps2_key_data  input  8  received PS/2 byte
- game_tick  input  1  one-cycle strobe: bikes advance one cell; commit point for turns
- heading  output  2*NUM_PLAYERS  per-player direction: 00 up, 01 right, 10 down, 11 left
- pending  output  NUM_PLAYERS  per-player flag: an uncommitted turn request is held
- turn_strobe  output  NUM_PLAYERS  one-cycle pulse: heading changed this cycle
- reject_strobe  output  NUM_PLAYERS  one-cycle pulse: pending request discarded as a reversal

## Operation
- Prefix FSM. State advances only on cycles with ps2_key_pressed=1.
  - IDLE: E0→EXT; F0→BRK; any other byte = make code {0,byte}, stay IDLE.
  - EXT: F0→EXT_BRK; E0→stay EXT; other byte = make code {1,byte}, →IDLE.
  - BRK: any byte is discarded (key release), →IDLE.
  - EXT_BRK: any byte is discarded, →IDLE.
- Match:
  - A make code equal to a player's entry d sets that player's pending=1 and pend_dir=d.
  - Latest request wins: a new match overwrites an existing pending request.
  - Typematic repeats simply rewrite the same request.
- Keymap collisions:
  - If one code matches several players, every matching player captures it.
  - Within one player, the lowest direction index wins (up > right > down > left).
- Commit on game_tick, per player with pending=1:
  - If pend_dir is the opposite of heading (XOR 2'b10) and reversal lockout is enabled: heading is unchanged and reject_strobe=1.
  - Else if pend_dir == heading: heading is unchanged, and neither strobe fires.
  - Else: heading=pend_dir and turn_strobe=1.
  - In every case, pending is cleared.
- game_tick with pending=0 is a no-op for that player.
- Reset values: FSM=IDLE, heading=INIT_HEADING, pending=0, pend_dir=0, turn_strobe=0, reject_strobe=0.

## Timing
- Byte accepted at edge t → pending/pend_dir visible after edge t (1-cycle latency).
  - The second byte of a prefixed sequence is the one that produces the capture.
- game_tick sampled at edge t → heading, turn_strobe and reject_strobe valid after edge t.
  - Strobes are high for exactly one cycle.
- A key byte and game_tick in the same cycle:
  - The tick commits the request already held, if any; the new byte then becomes the next pending request.
  - If nothing was pending, the new byte does not commit on this tick.
- Reset asserted in any cycle, including mid-prefix or coincident with a tick, wins over every other event.
  - A prefix interrupted by reset is forgotten.
- ps2_key_pressed=0 never changes FSM state.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BIKE_REVERSE_LOCK_EN:
  - Defined: a 180° request is rejected at commit, as described above.
  - Undefined: a 180° request commits like any other turn, and reject_strobe is tied to 0.

## Test plan
- Reset with defaults → heading=4'b1101, pending=2'b00, no strobes; hold 10 cycles, nothing changes.
- P0 bytes 1D, then game_tick → pending[0]=1 after the byte; after the tick heading[1:0]=00, turn_strobe=2'b01 for one cycle, pending[0]=0.
- Bytes E0,6B, then tick → after E0 pending stays 0; after 6B pending[1]=1; after the tick heading[3:2]=11 is unchanged and there are no strobes. Repeat with E0,75 → heading[3:2]=00 and turn_strobe[1]=1.
- Break sequences F0,1D and E0,F0,75, then tick → no pending set, no heading change; FSM back in IDLE (next 1D captures normally).
- P0 heading right, byte 1C (left), then tick → with BIKE_REVERSE_LOCK_EN: heading stays 01 and reject_strobe[0]=1. Without it: heading=11 and turn_strobe[0]=1.
- Byte 1B arriving in the same cycle as a tick, with P0 pending up → heading commits to up; pending[0]=1 with pend_dir down. Next tick → reversal rule applies. Then assert reset after E0 alone: a following 75 captures as plain code 075 (no match).

Source files
------------

// File: rtl/bike_heading_ctrl.sv
// Registered multi-player steering controller: decodes the PS/2 byte stream against
// a per-player keymap and commits turns on game_tick. Optional macro: BIKE_REVERSE_LOCK_EN.
module bike_heading_ctrl #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter logic [36*NUM_PLAYERS-1:0] KEYMAP = {9'h175, 9'h174, 9'h172, 9'h16B,
                                                 9'h01D, 9'h023, 9'h01B, 9'h01C},
  parameter logic [2*NUM_PLAYERS-1:0] INIT_HEADING = {2'b11, 2'b01}
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ps2_key_pressed,
  input  logic [7:0]               ps2_key_data,
  input  logic                     game_tick,
  output logic [2*NUM_PLAYERS-1:0] heading,
  output logic [NUM_PLAYERS-1:0]   pending,
  output logic [NUM_PLAYERS-1:0]   turn_strobe,
  output logic [NUM_PLAYERS-1:0]   reject_strobe
);

  localparam int unsigned KEY_W   = 9;
  localparam int unsigned SLICE_W = 4 * KEY_W;
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t                          state, state_nxt;
  logic [NUM_PLAYERS-1:0][1:0]     pend_dir, pend_dir_nxt;
  logic [2*NUM_PLAYERS-1:0]        heading_nxt;
  logic [NUM_PLAYERS-1:0]          pending_nxt, turn_nxt, reject_nxt;

  logic                            make_valid_c;
  logic [KEY_W-1:0]                make_code_c;
  logic [NUM_PLAYERS-1:0]          hit_c;
  logic [NUM_PLAYERS-1:0][1:0]     hit_dir_c;

  // Prefix decode: only a completed make code leaves make_valid_c set.
  always_comb begin
    state_nxt    = state;
    make_valid_c = 1'b0;
    make_code_c  = '0;
    if (ps2_key_pressed) begin
      unique case (state)
        ST_IDLE: begin
          if (ps2_key_data == BYTE_EXT)      state_nxt = ST_EXT;
          else if (ps2_key_data == BYTE_BRK) state_nxt = ST_BRK;
          else begin
            make_valid_c = 1'b1;
            make_code_c  = {1'b0, ps2_key_data};
          end
        end
        ST_EXT: begin
          if (ps2_key_data == BYTE_BRK)      state_nxt = ST_EXT_BRK;
          else if (ps2_key_data == BYTE_EXT) state_nxt = ST_EXT;
          else begin
            make_valid_c = 1'b1;
            make_code_c  = {1'b1, ps2_key_data};
            state_nxt    = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Keymap match; scanning left..up lets the lowest direction index win.
  always_comb begin
    hit_c     = '0;
    hit_dir_c = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      for (int d = 3; d >= 0; d--) begin
        if (make_valid_c &&
            make_code_c == KEYMAP[p*int'(SLICE_W) + (3-d)*int'(KEY_W) +: KEY_W]) begin
          hit_c[p]     = 1'b1;
          hit_dir_c[p] = 2'(d);
        end
      end
    end
  end

  // Tick commits the held request first; a same-cycle match becomes the next request.
  always_comb begin
    heading_nxt  = heading;
    pending_nxt  = pending;
    pend_dir_nxt = pend_dir;
    turn_nxt     = '0;
    reject_nxt   = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      if (game_tick && pending[p]) begin
        pending_nxt[p] = 1'b0;
        if (pend_dir[p] == (heading[2*p +: 2] ^ 2'b10)) begin
`ifdef BIKE_REVERSE_LOCK_EN
          reject_nxt[p] = 1'b1;
`else
          heading_nxt[2*p +: 2] = pend_dir[p];
          turn_nxt[p]           = 1'b1;
`endif
        end else if (pend_dir[p] != heading[2*p +: 2]) begin
          heading_nxt[2*p +: 2] = pend_dir[p];
          turn_nxt[p]           = 1'b1;
        end
      end
      if (hit_c[p]) begin
        pending_nxt[p]  = 1'b1;
        pend_dir_nxt[p] = hit_dir_c[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      heading       <= INIT_HEADING;
      pending       <= '0;
      pend_dir      <= '0;
      turn_strobe   <= '0;
      reject_strobe <= '0;
    end else begin
      state         <= state_nxt;
      heading       <= heading_nxt;
      pending       <= pending_nxt;
      pend_dir      <= pend_dir_nxt;
      turn_strobe   <= turn_nxt;
      reject_strobe <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_bike_heading_ctrl.sv
// Bench for bike_heading_ctrl: directed scenarios then random byte/tick/reset traffic,
// compared each cycle against a sequence-level behavioural model.
module tb_bike_heading_ctrl;

  localparam int unsigned NP = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            ps2_key_pressed = 1'b0;
  logic [7:0]      ps2_key_data = 8'h00;
  logic            game_tick = 1'b0;
  logic [2*NP-1:0] heading;
  logic [NP-1:0]   pending, turn_strobe, reject_strobe;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bike_heading_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data   (ps2_key_data),
    .game_tick      (game_tick),
    .heading        (heading),
    .pending        (pending),
    .turn_strobe    (turn_strobe),
    .reject_strobe  (reject_strobe)
  );

  // Reference keymap: {ext,code} per player, index 0..3 = up,right,down,left.
  int keys [NP][4] = '{'{'h01D, 'h023, 'h01B, 'h01C}, '{'h175, 'h174, 'h172, 'h16B}};
  int init_hd [NP] = '{1, 3};

  int m_hd [NP];
  int m_pdir [NP];
  bit m_pend [NP];
  bit m_turn [NP];
  bit m_rej [NP];
  int seq [$];

`ifdef BIKE_REVERSE_LOCK_EN
  bit lock = 1'b1;
`else
  bit lock = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Prefix bytes collected since the last completed code decide what a byte means.
  task automatic model_byte(input int b);
    bit brk = 1'b0;
    bit ext = 1'b0;
    int code;
    foreach (seq[i]) begin
      if (seq[i] == 'hF0) brk = 1'b1;
      if (seq[i] == 'hE0) ext = 1'b1;
    end
    if (brk) seq.delete();
    else if (b == 'hE0 || b == 'hF0) seq.push_back(b);
    else begin
      code = (ext ? 256 : 0) + b;
      seq.delete();
      for (int p = 0; p < int'(NP); p++) begin
        for (int d = 0; d < 4; d++) begin
          if (keys[p][d] == code) begin
            m_pend[p] = 1'b1;
            m_pdir[p] = d;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_cycle(input bit kp, input int kd, input bit tk, input bit rs);
    for (int p = 0; p < int'(NP); p++) begin
      m_turn[p] = 1'b0;
      m_rej[p]  = 1'b0;
    end
    if (rs) begin
      seq.delete();
      for (int p = 0; p < int'(NP); p++) begin
        m_hd[p] = init_hd[p]; m_pend[p] = 1'b0; m_pdir[p] = 0;
      end
      return;
    end
    if (tk) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (m_pend[p]) begin
          if (lock && (m_pdir[p] + 2) % 4 == m_hd[p]) m_rej[p] = 1'b1;
          else if (m_pdir[p] != m_hd[p]) begin
            m_hd[p]   = m_pdir[p];
            m_turn[p] = 1'b1;
          end
          m_pend[p] = 1'b0;
        end
      end
    end
    if (kp) model_byte(kd);
  endtask

  task automatic step(input bit kp, input logic [7:0] kd, input bit tk, input bit rs);
    logic [2*NP-1:0] eh;
    logic [NP-1:0]   ep, et, er;
    ps2_key_pressed = kp;
    ps2_key_data    = kd;
    game_tick       = tk;
    reset           = rs;
    @(posedge clock);
    model_cycle(kp, int'(kd), tk, rs);
    #1;
    for (int p = 0; p < int'(NP); p++) begin
      eh[2*p +: 2] = 2'(m_hd[p]);
      ep[p] = m_pend[p];
      et[p] = m_turn[p];
      er[p] = m_rej[p];
    end
    chk("heading", 32'(heading), 32'(eh));
    chk("pending", 32'(pending), 32'(ep));
    chk("turn_strobe", 32'(turn_strobe), 32'(et));
    chk("reject_strobe", 32'(reject_strobe), 32'(er));
    ps2_key_pressed = 1'b0;
    game_tick       = 1'b0;
    reset           = 1'b0;
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h23, 8'h1B, 8'h1C,
                            8'h75, 8'h74, 8'h72, 8'h6B, 8'h00, 8'h00};

  initial begin
    logic [7:0] b;
    // Reset and quiet hold.
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0);
    // P0 up via plain make code.
    step(1, 8'h1D, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    // P1 extended: left (no change) then up.
    step(1, 8'hE0, 0, 0);
    step(1, 8'h6B, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'h75, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    // Break sequences are ignored and return the decoder to idle.
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1D, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h23, 0, 0);
    step(0, 8'h00, 1, 0);
    // Reversal from right to left.
    step(1, 8'h1C, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    // Same-cycle byte and tick, then reversal of the new request.
    step(0, 8'h00, 0, 1);
    step(1, 8'h1D, 0, 0);
    step(1, 8'h1B, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    // Reset mid-prefix forgets the E0.
    step(1, 8'hE0, 0, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h75, 0, 0);
    step(0, 8'h00, 1, 0);
    // Collision: a key plus keypress during reset is ignored.
    step(1, 8'h1D, 1, 1);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      b = pool[$urandom_range(11)];
      if (b == 8'h00) b = 8'($urandom_range(255));
      step(($urandom_range(99) < 45), b, ($urandom_range(99) < 15), ($urandom_range(199) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
